board_lock_clear: RTL and testbench
===================================

// Module: board_lock_clear
// PURPOSE
// - Playfield owner: locks a landed 4x4 piece mask into the 500-cell board, then clears full rows.
// - Sits downstream of the piece generator/mover. Consumes the piece mask and anchor cell.
// - Produces the board vector used for collision and rotation checks, plus next-piece load requests.
// - Also outputs per-lock line count, running score and sticky game-over.
// PARAMETERS
// COLS     20   board width in cells; row stride of the board index
// ROWS     25   board height in rows; row 0 is top, gravity toward higher index
// CELLS    500  COLS*ROWS; width of board vector
// SCORE_W  16   width of score accumulator
// PORTS
// clk            in   1        clock
// rst_n          in   1        async active-low reset
// clear_board    in   1        sync new-game: empty board, zero score, clear game_over
// lock_req       in   1        pulse: lock current piece (sampled only in IDLE)
// piece_mask     in   16       4x4 mask; bit k = row k/4, col k%4
// piece_pos      in   9        board index of mask bit 0
// board          out  CELLS    occupied cells; index = row*COLS+col
// lock_busy      out  1        high from capture edge until lock_done
// lock_done      out  1        1-cycle pulse: merge+clear complete
// load_next      out  1        1-cycle pulse, coincident with lock_done; suppressed if game_over
// lines_cleared  out  3        rows cleared by last lock (0..4); held until next lock_done
// score          out  SCORE_W  running sum of lines_cleared, saturating at all-ones
// game_over      out  1        sticky until clear_board or reset
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, board all-zero.
// - FSM: IDLE -> MERGE -> SCAN -> DONE -> IDLE.
// - IDLE: on lock_req && !game_over, latch mask/pos, set lock_busy, go MERGE.
//   lock_req in any other state, or while game_over, is ignored (no queueing).
// - MERGE (1 cycle): for each set bit k, board[pos + (k/4)*COLS + k%4] <= 1.
//   Linear index arithmetic; column overflow wraps into the next row. Range checks belong to the piece mover.
//   Index >= CELLS: the bit is dropped and game_over is set.
//   Cell already occupied: OR it in and set game_over.
//   Then row_ptr <= ROWS-1, go SCAN.
// - SCAN, one action per cycle:
//   - Row row_ptr full (all COLS bits set): rows 1..row_ptr <= rows 0..row_ptr-1, row 0 <= 0, count++, row_ptr unchanged.
//   - Else if row_ptr==0: go DONE.
//   - Else row_ptr--.
// - DONE: assert lock_done/load_next for 1 cycle. Update lines_cleared <= count and score += count (saturating).
//   Set game_over if any row-0 cell is occupied. Drop lock_busy, go IDLE.
// - Latency: lock_req sampled at edge N -> lock_done high after edge N+2+ROWS+L (L = rows cleared).
//   Example: N+27 for L=0 with default params.
// - count is 3 bits. It cannot exceed 4 in legal play; saturate at 7 defensively.
// - clear_board has priority over everything in any state:
//   board/score/lines_cleared/game_over <= 0, pulses 0, state IDLE.
//   A lock in progress is abandoned.
// - Reset mid-operation: same as clear_board, but asynchronous.
// - board changes only in MERGE, SCAN-shift and clear. It is stable while IDLE.
// STRUCTURE
// - Shared package (tetris_pkg): COLS, ROWS, CELLS, state enum, mask_offset(k) = (k/4)*COLS + k%4.
//   The piece generator's rotation check uses the same offset function.
// - One sub-module: board_row_shift. Combinational; given board and row_ptr, returns row_full and the shifted board.
//   Keeps the FSM file small.
// TESTING
// - Empty board, mask 0x0660 at pos 0 -> cells 21,22,41,42 set.
//   lock_done at N+27, lines_cleared 0, load_next pulses.
// - Bottom row cells 480..495 pre-filled, lock mask 0x000F at pos 496 -> row 24 cleared.
//   Row 23 contents move to row 24, lines_cleared 1, score 1, lock_done at N+28.
// - Rows 21..24 all full except col 0; lock vertical I (0x1111) at pos 420.
//   -> lines_cleared 4, board all-zero, score +4.
// - Lock onto an occupied cell, or pos 490 with mask 0xFFFF (out of range).
//   -> game_over=1, load_next suppressed, later lock_req ignored.
// - Assert clear_board mid-SCAN -> next cycle board=0, score=0, state IDLE, no lock_done.
//   A lock_req the following cycle is processed normally.
// - lock_req pulsed again while lock_busy -> ignored.
//   Exactly one lock_done; score reaches all-ones and holds (saturation, forced via SCORE_W=3).

Source files
------------

// File: rtl/board_lock_clear_pkg.sv
// Playfield geometry, FSM state codes and piece-mask helpers for the lock/clear path.
// The piece generator's rotation check uses the same mask_offset() so both sides agree on cell placement.
package board_lock_clear_pkg;

    localparam int COLS  = 20;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;
    localparam int POS_W = 9;
    localparam int ROW_W = 5;
    localparam int CNT_W = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MERGE = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic [15:0]      mask;
        logic [POS_W-1:0] pos;
    } piece_t;

    // Linear board offset of mask bit k relative to the anchor cell.
    function automatic logic [9:0] mask_offset(input int k);
        return 10'((k / 4) * COLS + (k % 4));
    endfunction

endpackage

// File: rtl/board_lock_clear_row_shift.sv
// Row-clear helper: reports whether row i_row_ptr is full and produces the board
// with rows 0..i_row_ptr-1 dropped one row and row 0 emptied.
module board_lock_clear_row_shift
    import board_lock_clear_pkg::*;
(
    input  logic [CELLS-1:0] i_board,
    input  logic [ROW_W-1:0] i_row_ptr,
    output logic             o_row_full,
    output logic [CELLS-1:0] o_board_shifted
);

    always_comb begin
        o_row_full      = 1'b0;
        o_board_shifted = i_board;
        for (int r = 0; r < ROWS; r++) begin
            if (ROW_W'(r) == i_row_ptr) begin
                o_row_full = &i_board[r*COLS +: COLS];
            end
        end
        // Rows below i_row_ptr keep their contents; the cleared row is overwritten from above.
        for (int r = 1; r < ROWS; r++) begin
            if (ROW_W'(r) <= i_row_ptr) begin
                o_board_shifted[r*COLS +: COLS] = i_board[(r-1)*COLS +: COLS];
            end
        end
        o_board_shifted[0 +: COLS] = '0;
    end

endmodule

// File: rtl/board_lock_clear.sv
// Playfield owner: merges a landed 4x4 piece into the board, then clears full rows bottom-up.
//   state   | meaning
//   S_IDLE  | board stable, waiting for lock_req
//   S_MERGE | OR latched piece into board, flag out-of-range/overlap
//   S_SCAN  | one row test or shift per cycle, row_ptr walks bottom to top
//   S_DONE  | pulse lock_done/load_next, update lines/score, top-row check
module board_lock_clear
    import board_lock_clear_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear_board,
    input  logic               i_lock_req,
    input  logic [15:0]        i_piece_mask,
    input  logic [POS_W-1:0]   i_piece_pos,
    output logic [CELLS-1:0]   o_board,
    output logic               o_lock_busy,
    output logic               o_lock_done,
    output logic               o_load_next,
    output logic [2:0]         o_lines_cleared,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_game_over
);

    logic [1:0]         r_state;
    piece_t             r_piece;
    logic [ROW_W-1:0]   r_row_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CELLS-1:0]   r_board;
    logic               r_busy;
    logic               r_done;
    logic               r_load;
    logic               r_go;
    logic [2:0]         r_lines;
    logic [SCORE_W-1:0] r_score;

    logic [CELLS-1:0]   w_merged;
    logic [CELLS-1:0]   w_shifted;
    logic               w_oob;
    logic               w_overlap;
    logic               w_row_full;
    logic               w_row0_occ;
    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_next;

    board_lock_clear_row_shift u_row_shift (
        .i_board         (r_board),
        .i_row_ptr       (r_row_ptr),
        .o_row_full      (w_row_full),
        .o_board_shifted (w_shifted)
    );

    // Column overflow wraps into the next row by design; only the board end is checked.
    always_comb begin
        logic [9:0] v_idx;
        v_idx     = '0;
        w_merged  = r_board;
        w_oob     = 1'b0;
        w_overlap = 1'b0;
        for (int k = 0; k < 16; k++) begin
            v_idx = 10'(r_piece.pos) + mask_offset(k);
            if (r_piece.mask[k]) begin
                if (v_idx >= 10'(CELLS)) begin
                    w_oob = 1'b1;
                end else begin
                    if (r_board[v_idx[8:0]]) w_overlap = 1'b1;
                    w_merged[v_idx[8:0]] = 1'b1;
                end
            end
        end
    end

    assign w_row0_occ   = |r_board[COLS-1:0];
    assign w_score_sum  = {1'b0, r_score} + (SCORE_W+1)'(r_count);
    assign w_score_next = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_piece   <= '0;
            r_row_ptr <= '0;
            r_count   <= '0;
            r_board   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_load    <= 1'b0;
            r_go      <= 1'b0;
            r_lines   <= '0;
            r_score   <= '0;
        end else if (i_clear_board) begin
            r_state   <= S_IDLE;
            r_piece   <= '0;
            r_row_ptr <= '0;
            r_count   <= '0;
            r_board   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_load    <= 1'b0;
            r_go      <= 1'b0;
            r_lines   <= '0;
            r_score   <= '0;
        end else begin
            r_done <= 1'b0;
            r_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_lock_req && !r_go) begin
                        r_piece.mask <= i_piece_mask;
                        r_piece.pos  <= i_piece_pos;
                        r_busy       <= 1'b1;
                        r_state      <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    r_board   <= w_merged;
                    if (w_oob || w_overlap) r_go <= 1'b1;
                    r_row_ptr <= ROW_W'(ROWS - 1);
                    r_count   <= '0;
                    r_state   <= S_SCAN;
                end
                S_SCAN: begin
                    // A cleared row is re-tested at the same pointer since new contents dropped into it.
                    if (w_row_full) begin
                        r_board <= w_shifted;
                        if (r_count != '1) r_count <= r_count + 1'b1;
                    end else if (r_row_ptr == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_row_ptr <= r_row_ptr - 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_load  <= !(r_go || w_row0_occ);
                    r_lines <= r_count;
                    r_score <= w_score_next;
                    if (w_row0_occ) r_go <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_board         = r_board;
    assign o_lock_busy     = r_busy;
    assign o_lock_done     = r_done;
    assign o_load_next     = r_load;
    assign o_lines_cleared = r_lines;
    assign o_score         = r_score;
    assign o_game_over     = r_go;

endmodule

// File: tb/tb_board_lock_clear.sv
// Bench for board_lock_clear: directed and random locks checked against a row-list board model.
// A second instance with a 3-bit score shares all stimulus to exercise score saturation.
module tb_board_lock_clear;
    import board_lock_clear_pkg::*;

    localparam int SAT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear_board = 1'b0;
    logic             lock_req = 1'b0;
    logic [15:0]      piece_mask = '0;
    logic [POS_W-1:0] piece_pos = '0;

    logic [CELLS-1:0] board, board_s;
    logic             busy, done, load, go;
    logic             busy_s, done_s, load_s, go_s;
    logic [2:0]       lines, lines_s;
    logic [15:0]      score;
    logic [SAT_W-1:0] score_s;

    always #5 clk = ~clk;

    board_lock_clear #(.SCORE_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_clear_board(clear_board), .i_lock_req(lock_req),
        .i_piece_mask(piece_mask), .i_piece_pos(piece_pos), .o_board(board),
        .o_lock_busy(busy), .o_lock_done(done), .o_load_next(load),
        .o_lines_cleared(lines), .o_score(score), .o_game_over(go)
    );

    board_lock_clear #(.SCORE_W(SAT_W)) u_sat (
        .clk(clk), .rst_n(rst_n), .i_clear_board(clear_board), .i_lock_req(lock_req),
        .i_piece_mask(piece_mask), .i_piece_pos(piece_pos), .o_board(board_s),
        .o_lock_busy(busy_s), .o_lock_done(done_s), .o_load_next(load_s),
        .o_lines_cleared(lines_s), .o_score(score_s), .o_game_over(go_s)
    );

    // Reference model: board as a list of rows, row 0 on top.
    logic [COLS-1:0] m_row [ROWS];
    bit              m_go;
    int              m_total;
    int              checks = 0;
    int              failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_board(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        foreach (m_row[r]) m_row[r] = '0;
        m_go    = 1'b0;
        m_total = 0;
    endfunction

    function automatic logic [CELLS-1:0] m_flat();
        logic [CELLS-1:0] f;
        f = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                f[r*COLS + c] = m_row[r][c];
        return f;
    endfunction

    function automatic int exp_score16();
        return (m_total > 65535) ? 65535 : m_total;
    endfunction

    function automatic int exp_score3();
        return (m_total > 7) ? 7 : m_total;
    endfunction

    // Place piece, then drop all full rows out of the stack; returns rows removed.
    function automatic int model_lock(input logic [15:0] mask, input int pos);
        logic [COLS-1:0] kept [$];
        int n_full;
        n_full = 0;
        for (int k = 0; k < 16; k++) begin
            if (mask[k]) begin
                int idx;
                idx = pos + (k / 4) * COLS + (k % 4);
                if (idx >= CELLS) begin
                    m_go = 1'b1;
                end else begin
                    if (m_row[idx / COLS][idx % COLS]) m_go = 1'b1;
                    m_row[idx / COLS][idx % COLS] = 1'b1;
                end
            end
        end
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (m_row[r] == '1) n_full++;
            else kept.push_back(m_row[r]);
        end
        for (int r = ROWS - 1; r >= 0; r--)
            m_row[r] = (kept.size() > 0) ? kept.pop_front() : '0;
        if (m_row[0] != '0) m_go = 1'b1;
        if (n_full > 7) n_full = 7;
        m_total += n_full;
        return n_full;
    endfunction

    task automatic do_lock(input logic [15:0] mask, input int pos, input bit repulse);
        int e;
        int exp_l;
        int n_done;
        bit was_go;
        was_go = m_go;
        @(negedge clk);
        piece_mask = mask;
        piece_pos  = POS_W'(pos);
        lock_req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lock_req = 1'b0;
        if (was_go) begin
            n_done = 0;
            repeat (30) begin
                @(negedge clk);
                if (done) n_done++;
            end
            chk("ignored_busy", int'(busy), 0);
            chk("ignored_done", n_done, 0);
            chk("ignored_go", int'(go), 1);
            chk_board("ignored_board", board, m_flat());
            return;
        end
        chk("busy_after_capture", int'(busy), 1);
        exp_l = model_lock(mask, pos);
        e = 0;
        do begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (repulse) lock_req = (e == 5);
        end while (!done && e < 100);
        lock_req = 1'b0;
        chk("latency", e, 2 + ROWS + exp_l);
        chk("lines", int'(lines), exp_l);
        chk("load_next", int'(load), int'(!m_go));
        chk("game_over", int'(go), int'(m_go));
        chk("busy_at_done", int'(busy), 0);
        chk("score", int'(score), exp_score16());
        chk_board("board", board, m_flat());
        chk("sat_done", int'(done_s), 1);
        chk("sat_score", int'(score_s), exp_score3());
        chk("sat_lines", int'(lines_s), exp_l);
        chk("sat_load", int'(load_s), int'(!m_go));
        chk("sat_go", int'(go_s), int'(m_go));
        chk("sat_busy", int'(busy_s), 0);
        chk_board("sat_board", board_s, m_flat());
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("lines_held", int'(lines), exp_l);
        if (repulse) begin
            n_done = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) n_done++;
            end
            chk("repulse_extra_done", n_done, 0);
            chk("repulse_busy", int'(busy), 0);
            chk_board("repulse_board", board, m_flat());
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_board = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_board = 1'b0;
        m_reset();
        chk_board("clear_board", board, '0);
        chk("clear_score", int'(score), 0);
        chk("clear_lines", int'(lines), 0);
        chk("clear_go", int'(go), 0);
        chk("clear_busy", int'(busy), 0);
        chk("clear_done", int'(done), 0);
    endtask

    initial begin
        logic [CELLS-1:0] t;
        m_reset();

        repeat (2) @(negedge clk);
        chk_board("rst_board", board, '0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_lines", int'(lines), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_go", int'(go), 0);
        rst_n = 1'b1;

        // O piece in an empty board.
        do_lock(16'h0660, 0, 1'b0);
        t = '0;
        t[21] = 1'b1; t[22] = 1'b1; t[41] = 1'b1; t[42] = 1'b1;
        chk_board("o_piece_cells", board, t);

        // Four rows full except column 0, closed by a vertical I; done twice to saturate the 3-bit score.
        do_clear();
        repeat (2) begin
            do_lock(16'hFFFF, 421, 1'b0);
            do_lock(16'hFFFF, 425, 1'b0);
            do_lock(16'hFFFF, 429, 1'b0);
            do_lock(16'hFFFF, 433, 1'b0);
            do_lock(16'h7777, 437, 1'b0);
            do_lock(16'h1111, 420, 1'b1);
            chk_board("tetris_empty", board, '0);
        end
        chk("score_after_two_tetris", int'(score), 8);
        chk("sat_score_capped", int'(score_s), 7);

        // Single bottom-row clear; the row-23 block drops into row 24.
        do_lock(16'h0001, 460, 1'b0);
        do_lock(16'h000F, 480, 1'b0);
        do_lock(16'h000F, 484, 1'b0);
        do_lock(16'h000F, 488, 1'b0);
        do_lock(16'h000F, 492, 1'b0);
        do_lock(16'h000F, 496, 1'b0);
        t = '0;
        t[480] = 1'b1;
        chk_board("single_clear_board", board, t);
        chk("single_clear_score", int'(score), 9);
        chk("sat_score_holds", int'(score_s), 7);

        // Overlap: same O piece twice -> game over, later locks ignored.
        do_lock(16'h0660, 0, 1'b0);
        do_lock(16'h0660, 0, 1'b0);
        chk("overlap_go", int'(go), 1);
        do_lock(16'h0001, 300, 1'b0);

        // Out of range.
        do_clear();
        do_lock(16'hFFFF, 490, 1'b0);
        chk("oob_go", int'(go), 1);

        // clear_board in the middle of a scan, then a normal lock right after.
        do_clear();
        do_lock(16'h0660, 200, 1'b0);
        @(negedge clk);
        piece_mask = 16'h0033;
        piece_pos  = POS_W'(300);
        lock_req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lock_req = 1'b0;
        repeat (10) @(negedge clk);
        do_clear();
        do_lock(16'h0660, 100, 1'b0);

        // Asynchronous reset mid-lock.
        @(negedge clk);
        piece_mask = 16'h0660;
        piece_pos  = POS_W'(200);
        lock_req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lock_req = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_board("async_rst_board", board, '0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_score", int'(score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();

        // Random games against the model.
        repeat (4) begin
            do_clear();
            repeat (8) begin
                logic [15:0] rm;
                int          rp;
                rm = 16'($urandom) & 16'($urandom);
                if (rm == '0) rm = 16'h0001;
                rp = int'($urandom_range(60, 499));
                do_lock(rm, rp, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
